// File: rtl/pif_fq_if.sv
// Fetch-queue bundle: redirect, instruction ROM port, decode-side output and occupancy.
// The master modport is the fetch unit; the slave modport is its environment.
interface pif_fq_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             jump_ce;
    logic [WIDTH-1:0] jump_pc;
    logic             rom_ce;
    logic [WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_inst;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_inst;
    logic [WIDTH-1:0] out_pc;
    logic [LW-1:0]    level;

    modport master (
        input  jump_ce, jump_pc, rom_inst, out_ready,
        output rom_ce, rom_addr, out_valid, out_inst, out_pc, level
    );

    modport slave (
        output jump_ce, jump_pc, rom_inst, out_ready,
        input  rom_ce, rom_addr, out_valid, out_inst, out_pc, level
    );
endinterface

// File: rtl/pif_fq.sv
// Instruction fetch unit with a small queue toward decode; redirects flush everything in flight.
// Optional PIF_FQ_BYPASS_EN forwards a response straight to the output when the queue is empty.
module pif_fq #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic      clk,
    input  logic      rst,
    pif_fq_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0]   pc_r;
    logic [WIDTH-1:0]   issue_pc_r;
    logic               inflight_r;
    logic [LW-1:0]      level_r;
    logic [PW-1:0]      head_r;
    logic [PW-1:0]      tail_r;
    logic [2*WIDTH-1:0] mem_r [DEPTH];

    logic               bypass_s;
    logic               out_valid_s;
    logic               pop_s;
    logic               q_pop_s;
    logic               push_s;
    logic               rom_ce_s;
    logic [LW:0]        need_s;
    logic [LW:0]        room_s;
    logic [2*WIDTH-1:0] head_entry_s;
    logic [WIDTH-1:0]   out_inst_s;
    logic [WIDTH-1:0]   out_pc_s;

    // Handshake, issue throttle and output selection.
    always_comb begin
        bypass_s = 1'b0;
`ifdef PIF_FQ_BYPASS_EN
        bypass_s = rst & (level_r == {LW{1'b0}}) & inflight_r;
`endif
        out_valid_s  = rst & ((level_r != {LW{1'b0}}) | bypass_s);
        pop_s        = out_valid_s & bus.out_ready;
        q_pop_s      = rst & (level_r != {LW{1'b0}}) & bus.out_ready;
        // A bypassed response that decode takes right away never enters the queue.
        push_s       = inflight_r & ~bus.jump_ce & ~(bypass_s & bus.out_ready);
        need_s       = {1'b0, level_r} + {{LW{1'b0}}, inflight_r};
        room_s       = (LW+1)'(DEPTH) + {{LW{1'b0}}, pop_s};
        rom_ce_s     = rst & ~bus.jump_ce & (need_s < room_s);
        head_entry_s = mem_r[head_r];
        if (bypass_s) begin
            out_pc_s   = issue_pc_r;
            out_inst_s = bus.rom_inst;
        end else begin
            out_pc_s   = head_entry_s[2*WIDTH-1:WIDTH];
            out_inst_s = head_entry_s[WIDTH-1:0];
        end
    end

    // Fetch PC, in-flight tracking, pointers and occupancy; a redirect acts as a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r       <= RESET_PC;
            issue_pc_r <= RESET_PC;
            inflight_r <= 1'b0;
            level_r    <= {LW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
        end else if (bus.jump_ce) begin
            pc_r       <= bus.jump_pc;
            inflight_r <= 1'b0;
            level_r    <= {LW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
        end else begin
            inflight_r <= rom_ce_s;
            if (rom_ce_s) begin
                pc_r       <= pc_r + WIDTH'(4);
                issue_pc_r <= pc_r;
            end
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (q_pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, q_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Queue storage; entries carry the issuing address alongside the instruction.
    always_ff @(posedge clk) begin
        if (rst & push_s) begin
            mem_r[tail_r] <= {issue_pc_r, bus.rom_inst};
        end
    end

    assign bus.rom_ce    = rom_ce_s;
    assign bus.rom_addr  = pc_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_inst  = out_inst_s;
    assign bus.out_pc    = out_pc_s;
    assign bus.level     = level_r;
endmodule

// File: tb/tb_pif_fq.sv
// Bench for pif_fq: directed scenarios plus randomized traffic against a queue-level reference model.
module tb_pif_fq;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef PIF_FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pif_fq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pif_fq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    // Instruction ROM: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        bus.rom_inst <= bus.rom_ce ? rom_f(bus.rom_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an in-order queue of fetched PCs plus one pending ROM response.
    logic [31:0] mq [$];
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = 32'h0;
    logic [31:0] m_pc = 32'h0;
    bit          model_ok = 1'b0;

    always @(negedge clk) begin : cmp
        bit          e_valid, e_pop, e_rom_ce, consumed;
        logic [31:0] e_head;
        int          occ;
        e_valid  = rst && (mq.size() > 0 || (BYP && m_infl));
        e_head   = (mq.size() > 0) ? mq[0] : m_infl_pc;
        e_pop    = e_valid && bus.out_ready;
        occ      = mq.size() + int'(m_infl) - int'(e_pop);
        e_rom_ce = rst && !bus.jump_ce && (occ < DEPTH);
        if (model_ok) begin
            chk("level", 32'(bus.level), 32'(mq.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
            chk("rom_ce", 32'(bus.rom_ce), 32'(e_rom_ce));
            if (rst) chk("rom_addr", bus.rom_addr, m_pc);
            if (e_valid) begin
                chk("out_pc", bus.out_pc, e_head);
                chk("out_inst", bus.out_inst, rom_f(e_head));
            end
        end
        if (!rst) begin
            mq.delete();
            m_infl   = 1'b0;
            m_pc     = RPC;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (bus.jump_ce) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = bus.jump_pc;
            end else begin
                consumed = 1'b0;
                if (e_pop) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    else consumed = 1'b1;
                end
                if (m_infl && !consumed) mq.push_back(m_infl_pc);
                m_infl    = e_rom_ce;
                m_infl_pc = m_pc;
                if (e_rom_ce) m_pc = m_pc + 32'd4;
            end
        end
    end

    initial begin
        bus.jump_ce   = 1'b0;
        bus.jump_pc   = 32'h0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;

        // Reset state, then release with decode always ready.
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        cyc();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("start_rom_ce", 32'(bus.rom_ce), 32'd1);
            chk("start_rom_addr", bus.rom_addr, RPC + 32'(4 * k));
            if (k >= LAT) begin
                chk("start_valid", 32'(bus.out_valid), 32'd1);
                chk("start_out_pc", bus.out_pc, RPC + 32'(4 * (k - LAT)));
            end else begin
                chk("start_valid", 32'(bus.out_valid), 32'd0);
            end
            cyc();
        end

        // Stall decode for 10 cycles: queue fills, fetch stops, order preserved on release.
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        repeat (10) cyc();
        @(negedge clk);
        chk("full_level", 32'(bus.level), 32'd4);
        chk("full_rom_ce", 32'(bus.rom_ce), 32'd0);
        chk("full_head", bus.out_pc, 32'h100);
        cyc();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_pc", bus.out_pc, 32'h100 + 32'(4 * k));
            cyc();
        end

        // Redirect at level 3 with a response in flight.
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        repeat (4) cyc();
        bus.jump_ce = 1'b1;
        bus.jump_pc = 32'h2000;
        @(negedge clk);
        chk("jmp_level_before", 32'(bus.level), 32'd3);
        chk("jmp_rom_ce", 32'(bus.rom_ce), 32'd0);
        cyc();
        bus.jump_ce = 1'b0;
        @(negedge clk);
        chk("jmp_level_after", 32'(bus.level), 32'd0);
        chk("jmp_valid_after", 32'(bus.out_valid), 32'd0);
        chk("jmp_rom_addr", bus.rom_addr, 32'h2000);
        for (int j = 1; j < 4; j++) begin
            cyc();
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (j >= LAT) chk("jmp_out_pc", bus.out_pc, 32'h2000 + 32'(4 * (j - LAT)));
            else          chk("jmp_valid", 32'(bus.out_valid), 32'd0);
        end

        // Redirect together with a pop at level 1.
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        repeat (2) cyc();
        bus.out_ready = 1'b1;
        bus.jump_ce   = 1'b1;
        bus.jump_pc   = 32'h3000;
        @(negedge clk);
        chk("jp_level_before", 32'(bus.level), 32'd1);
        chk("jp_head", bus.out_pc, 32'h100);
        cyc();
        bus.jump_ce = 1'b0;
        @(negedge clk);
        chk("jp_level_after", 32'(bus.level), 32'd0);
        chk("jp_valid_after", 32'(bus.out_valid), 32'd0);
        chk("jp_rom_addr", bus.rom_addr, 32'h3000);
        for (int j = 1; j < 4; j++) begin
            cyc();
            @(negedge clk);
            if (j >= LAT) chk("jp_out_pc", bus.out_pc, 32'h3000 + 32'(4 * (j - LAT)));
            else          chk("jp_valid", 32'(bus.out_valid), 32'd0);
        end

        // Fetch address wraps past the top of the address space.
        cyc();
        bus.jump_ce = 1'b1;
        bus.jump_pc = 32'hFFFF_FFFC;
        cyc();
        bus.jump_ce = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", bus.rom_addr, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk);
        chk("wrap_addr1", bus.rom_addr, 32'h0000_0000);
        repeat (4) cyc();

        // One-cycle reset mid-stream at level 2.
        rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_rom_ce", 32'(bus.rom_ce), 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_level", 32'(bus.level), 32'd0);
        chk("mrst_rom_addr", bus.rom_addr, RPC);
        chk("mrst_rom_ce_on", 32'(bus.rom_ce), 32'd1);

        // Randomized traffic: stalls, redirects and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst         = ($urandom_range(0, 299) != 0);
            bus.jump_ce = ($urandom_range(0, 19) == 0);
            bus.jump_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            if ((i % 500) < 250) bus.out_ready = ($urandom_range(0, 3) != 0);
            else                 bus.out_ready = ($urandom_range(0, 3) == 0);
        end
        cyc();
        bus.jump_ce = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pif_fq.md
PIF_FQ -- requirements
Module: pif_fq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction and PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: fetch-queue entries; power of two, minimum 2.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port jump_ce  input  1  redirect request from execute.
REQ-007 SHALL have port jump_pc  input  WIDTH  redirect target, valid when jump_ce=1.
REQ-008 SHALL have port rom_ce  output  1  instruction ROM read strobe.
REQ-009 SHALL have port rom_addr  output  WIDTH  ROM read address.
REQ-010 SHALL have port rom_inst  input  WIDTH  ROM data, valid exactly one cycle after rom_ce=1.
REQ-011 SHALL have port out_valid  output  1  queue head valid toward decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts head.
REQ-013 SHALL have port out_inst  output  WIDTH  head instruction.
REQ-014 SHALL have port out_pc  output  WIDTH  head instruction address.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL hold a fetch-PC register; rom_addr SHALL equal fetch-PC combinationally.
REQ-017 SHALL assert rom_ce when rst=1, jump_ce=0, and (level + inflight - pop) < DEPTH; inflight = 1 if a non-killed response is due this cycle; pop = out_valid & out_ready.
REQ-018 SHALL advance fetch-PC by 4 (modulo 2^WIDTH, wrap allowed) on each cycle with rom_ce=1.
REQ-019 SHALL write {rom_addr of the issuing cycle, rom_inst} into the queue tail in the cycle after issue, unless killed.
REQ-020 SHALL present the head entry on out_inst/out_pc with out_valid=1 whenever level>0; head contents SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 SHALL remove the head on pop; simultaneous push and pop SHALL leave level unchanged.
REQ-022 SHALL never overflow: REQ-017 guarantees a push is never made when level=DEPTH and pop=0.
REQ-023 SHALL, on jump_ce=1: load fetch-PC with jump_pc, clear the queue (level=0 next cycle), mark any in-flight response killed, and suppress rom_ce that cycle.
REQ-024 SHALL give jump_ce priority over simultaneous push and pop; a pop in the jump cycle is accepted, and its entry is discarded with the flush.
REQ-025 SHALL ignore pop when out_valid=0.
REQ-026 SHALL sustain one instruction per cycle with DEPTH>=2 when out_ready is held at 1.
REQ-027 SHALL implement head/tail pointers modulo DEPTH with wrap-around; level SHALL be a separate counter.

Reset
REQ-028 SHALL, while rst=0 at a clock edge: set fetch-PC=RESET_PC, level=0, pointers=0, kill in-flight response; out_valid=0 and rom_ce=0 while rst=0.
REQ-029 SHALL issue first fetch (rom_ce=1, rom_addr=RESET_PC) in the first cycle with rst=1.
REQ-030 SHALL treat reset asserted mid-operation identically to power-on reset; queue contents are discarded.

Configuration
REQ-031 SHALL support macro PIF_FQ_BYPASS_EN.
REQ-032 With PIF_FQ_BYPASS_EN defined: when the queue is empty and a non-killed response arrives, out_valid=1 and out_inst/out_pc SHALL show it that same cycle; if popped that cycle it SHALL not be written.
REQ-033 Without PIF_FQ_BYPASS_EN: out_valid SHALL rise only the cycle after the response is written (fetch-to-output latency 2 cycles instead of 1).

Verification
REQ-034 Reset release, RESET_PC=0x100, out_ready=1 -> rom_addr 0x100,0x104,0x108 on consecutive cycles; out_pc 0x100 first valid at cycle 2 (cycle 1 with bypass), then 1/cycle.
REQ-035 out_ready=0 for 10 cycles, DEPTH=4 -> level reaches 4, rom_ce drops, head stays out_pc=0x100; release -> 0x100..0x10C then 0x110 in order, no loss or duplicate.
REQ-036 jump_ce=1, jump_pc=0x2000 while level=3 and a fetch in flight -> next cycle level=0, killed data never appears, next out_pc=0x2000.
REQ-037 Simultaneous jump_ce and pop at level=1 -> level=0, no stale output, fetch resumes at jump_pc.
REQ-038 Fetch-PC=0xFFFFFFFC, WIDTH=32 -> next rom_addr=0x00000000.
REQ-039 rst=0 for one cycle mid-stream with level=2 -> out_valid=0, level=0, refetch starts at RESET_PC.
